// File: rtl/uart_tx_if.sv
// AXI-Stream style byte sink for the UART transmitter.
// The source drives tdata/tvalid and holds them until tready is seen.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register, LSB-first framing, optional parity, gapless frames.
// Define UART_TX_STOP2_EN for two stop bits; the default build sends one stop bit.
//
// state    | meaning
// IDLE     | line high, waiting for a buffered byte
// START    | start bit (low)
// DATA     | data bits, LSB first
// PARITY_S | parity bit (skipped when PARITY is "none")
// STOP     | stop bit(s), high; tx_done on the final cycle
module uart_tx #(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even"
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  s_axis,
  output logic      tx,
  output logic      busy,
  output logic      tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BCW      = $clog2(BAUD_DIV) + 1;
  localparam int BITW     = $clog2(DATA_BITS) + 1;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam bit HAS_PARITY = (PARITY != "none");
  localparam bit ODD_PARITY = (PARITY == "odd");

  localparam logic [BCW-1:0]  BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0]  BAUD_PRE  = BCW'(BAUD_DIV - 2);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_BITS - 1);
  localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_S,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_valid;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [BCW-1:0]       baud_cnt;
  logic [BITW-1:0]      bit_cnt;

  logic                 handshake;
  logic                 baud_end;
  logic                 stop_end;
  logic                 load;
  logic [DATA_BITS-1:0] shift_next;

  assign s_axis.tready = !hold_valid;
  assign busy          = (state != IDLE) || hold_valid;

  always_comb begin
    handshake  = s_axis.tvalid && !hold_valid;
    baud_end   = (baud_cnt == BAUD_LAST);
    stop_end   = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
    load       = hold_valid && ((state == IDLE) || stop_end);
    shift_next = shift >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // A new byte may be accepted on the same edge the buffered one is consumed.
      if (handshake) begin
        hold       <= s_axis.tdata;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        shift      <= hold;
        parity_bit <= (^hold) ^ ODD_PARITY;
      end

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (load) begin
            state <= START;
            tx    <= 1'b0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (HAS_PARITY) begin
                state <= PARITY_S;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BITW'(1);
              shift   <= shift_next;
              tx      <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end

        PARITY_S: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end

        STOP: begin
          // Registered one cycle early so the pulse lands on the final stop cycle.
          tx_done <= (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (load) begin
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BITW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BCW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter, the transmit-side counterpart of the team's UART receiver on the AXIS-to-UART path. Accepts bytes over an AXI-Stream-style valid/ready sink, buffers one byte, and serialises frames LSB-first with a configurable parity bit. A one-entry holding register lets frames go out back-to-back with no idle gap.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: bit rate. `BAUD_DIV = CLK_FREQ / BAUD` (integer truncation); `BAUD_DIV >= 2` is required.
- `DATA_BITS`, default 8: data bits per frame.
- `PARITY`, default "even": "none", "even" or "odd".

- `clk`  in  1: sole clock; all logic is on the rising edge.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `s_axis_tdata`  in  DATA_BITS: byte to transmit.
- `s_axis_tvalid`  in  1: tdata valid.
- `s_axis_tready`  out  1: holding register empty; equals `!hold_valid`.
- `tx`  out  1: serial line, registered, idle high.
- `busy`  out  1: FSM not in IDLE, or holding register occupied.
- `tx_done`  out  1: 1-cycle pulse when the last stop-bit period completes.

## Operation
- Reset values: `tx`=1, `s_axis_tready`=1, `busy`=0, `tx_done`=0. Holding register is empty, FSM is in IDLE, and both counters are 0.
- Handshake: a transfer occurs on an edge where `tvalid & tready`. tdata is latched into the holding register and `hold_valid` is set. While `hold_valid`=1, tready=0 and the upstream source must hold its data.
- FSM states: IDLE, START, DATA, PARITY_S, STOP.
  - IDLE: `tx`=1. If `hold_valid`, copy the holding register to the shift register, clear `hold_valid`, compute the parity bit, and go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: `tx`=`shift[0]`. Each bit lasts BAUD_DIV cycles, then the register shifts right. After bit DATA_BITS-1, go to PARITY_S, or to STOP if PARITY="none".
  - PARITY_S: `tx`=parity bit for BAUD_DIV cycles, then go to STOP. Even: `^data`. Odd: `~^data`.
  - STOP: `tx`=1 for BAUD_DIV cycles (2×BAUD_DIV with the macro below). On the last cycle, pulse `tx_done`. If `hold_valid`, load the next byte and go directly to START (gapless); otherwise go to IDLE.
- The holding register can refill during any state, including on the same edge it is emptied: if IDLE/STOP loads the byte while a new handshake occurs, the new byte enters the holding register and `hold_valid` stays 1.
- Parity is computed from the loaded byte, not from the line.
- The baud counter has width `$clog2(BAUD_DIV)+1` and counts 0..BAUD_DIV-1. The bit counter has width `$clog2(DATA_BITS)+1`.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronous), the holding register is discarded, and the FSM returns to IDLE. No `tx_done` is produced.

## Timing
- Handshake at edge N with FSM in IDLE: `hold_valid` rises at N; START is loaded at N+1; `tx` falls after N+1.
- Frame length: `(1 + DATA_BITS + P + S) × BAUD_DIV` cycles, where P=0 or 1 and S=1 (or 2 with the macro). Every bit lasts exactly BAUD_DIV cycles.
- `tx_done` is asserted for the final clock cycle of the stop period. The next START, if any, begins on the following edge.
- `s_axis_tready` is combinational from `hold_valid` with no dependence on `tvalid`. It returns to 1 the cycle after the FSM consumes the buffered byte.
- Throughput: sustained back-to-back operation with zero idle cycles between frames.

## Configuration
- `UART_TX_STOP2_EN`:
  - Defined: two stop bits, so STOP lasts 2×BAUD_DIV cycles, and `tx_done` fires on the last cycle of the second stop bit.
  - Undefined: one stop bit (BAUD_DIV cycles).
  - No other behaviour changes.

## Test plan
All scenarios use CLK_FREQ=50_000_000 and BAUD=115200, so BAUD_DIV=434.
- Single byte, even parity: send 0x55 -> `tx` pattern 0,1,0,1,0,1,0,1,0,0(parity),1(stop), each bit held 434 cycles; frame 4774 cycles; one `tx_done` pulse.
- Parity modes: send 0x07 -> parity bit 1 (even), 0 (odd), absent (none; frame 4340 cycles).
- Back-to-back: `tvalid` held high with 0xA5 then 0x3C -> second handshake accepted during the first frame; second start bit begins on the edge after `tx_done`; no idle cycles; `tready` low while buffered.
- Backpressure: `tvalid` held with 3 bytes -> `tready` deasserts while the buffer is full; all 3 bytes are transmitted in order with no loss or duplication.
- Reset mid-frame: `rst_n` pulled low during DATA bit 3 -> `tx`=1 asynchronously, `busy`=0, `tready`=1; no `tx_done`; the next byte after release gives a clean frame.
- `UART_TX_STOP2_EN` defined: send 0x55 with even parity -> frame 5208 cycles; stop-high time 868 cycles before `tx_done`.
